// File: rtl/passage_pkg.sv
// Shared encodings for the passage counter: FSM states, segment patterns, BCD helpers.
// Segments are active-low, bit6=a .. bit0=g.
package passage_pkg;

    localparam logic [0:0] ST_COUNTING = 1'b0;
    localparam logic [0:0] ST_ALERT    = 1'b1;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] units;
    } bcd_t;

    function automatic bcd_t bcd_inc(input bcd_t b);
        bcd_t r;
        r = b;
        if (b.units == 4'd9) begin
            r.units = 4'd0;
            r.tens  = b.tens + 4'd1;
        end else begin
            r.units = b.units + 4'd1;
        end
        return r;
    endfunction

    function automatic bcd_t bcd_dec(input bcd_t b);
        bcd_t r;
        r = b;
        if (b.units == 4'd0) begin
            r.units = 4'd9;
            r.tens  = b.tens - 4'd1;
        end else begin
            r.units = b.units - 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// BCD digit to active-low 7-segment pattern; purely combinational, no backpressure.
// Codes above 9 blank the digit.
module seg7_decoder
    import passage_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_bcd)
            4'd0: o_seg = 7'b0000001;
            4'd1: o_seg = 7'b1001111;
            4'd2: o_seg = 7'b0010010;
            4'd3: o_seg = 7'b0000110;
            4'd4: o_seg = 7'b1001100;
            4'd5: o_seg = 7'b0100100;
            4'd6: o_seg = 7'b0100000;
            4'd7: o_seg = 7'b0001111;
            4'd8: o_seg = 7'b0000000;
            4'd9: o_seg = 7'b0000100;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/passage_counter.sv
// Occupancy counter fed by gate passage events; count, BCD and FULL update on the sampling edge.
// No backpressure: FULL tells the gate to refuse entries, and events arriving during ALERT are dropped.
module passage_counter
    import passage_pkg::*;
#(
    parameter int CAPACITY     = 20,
    parameter int ALERT_CYCLES = 50
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_ev_valid,
    input  logic       i_ev_dir,
    output logic [6:0] o_count,
    output logic       o_full,
    output logic [6:0] o_hex1,
    output logic [6:0] o_hex0,
    output logic       o_ledg,
    output logic       o_ledr
);

    localparam int              TW     = (ALERT_CYCLES > 1) ? $clog2(ALERT_CYCLES) : 1;
    localparam logic [6:0]      CAP    = 7'(CAPACITY);
    localparam logic [TW-1:0]   RELOAD = TW'(ALERT_CYCLES - 1);
    localparam logic [TW-1:0]   ONE    = TW'(1);

    logic [0:0]    r_state;
    logic [6:0]    r_count;
    bcd_t          r_bcd;
    logic [TW-1:0] r_timer;
    logic          r_ev_q;

    logic          w_ev;
    logic          w_full;
    logic          w_alert;
    logic [6:0]    w_seg_tens;
    logic [6:0]    w_seg_units;

    // Rising-edge detect; r_ev_q resets high so a level already present at release is ignored.
    assign w_ev    = i_ev_valid & ~r_ev_q;
    assign w_full  = (r_count == CAP);
    assign w_alert = (r_state == ST_ALERT);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_COUNTING;
            r_count <= '0;
            r_bcd   <= '0;
            r_timer <= '0;
            r_ev_q  <= 1'b1;
        end else begin
            r_ev_q <= i_ev_valid;
            case (r_state)
                ST_COUNTING: begin
                    if (w_ev) begin
                        if (i_ev_dir && !w_full) begin
                            r_count <= r_count + 7'd1;
                            r_bcd   <= bcd_inc(r_bcd);
                        end else if (!i_ev_dir && (r_count != 7'd0)) begin
                            r_count <= r_count - 7'd1;
                            r_bcd   <= bcd_dec(r_bcd);
                        end else begin
                            r_timer <= RELOAD;
                            r_state <= ST_ALERT;
                        end
                    end
                end
                default: begin
                    // Dwell covers RELOAD..0 inclusive, i.e. ALERT_CYCLES cycles.
                    if (r_timer == '0) begin
                        r_state <= ST_COUNTING;
                    end else begin
                        r_timer <= r_timer - ONE;
                    end
                end
            endcase
        end
    end

    seg7_decoder u_seg_tens (
        .i_bcd (r_bcd.tens),
        .o_seg (w_seg_tens)
    );

    seg7_decoder u_seg_units (
        .i_bcd (r_bcd.units),
        .o_seg (w_seg_units)
    );

    assign o_count = r_count;
    assign o_full  = w_full;
    assign o_hex1  = w_alert ? SEG_E :
                     (r_bcd.tens == 4'd0) ? SEG_BLANK : w_seg_tens;
    assign o_hex0  = w_alert ? SEG_DASH : w_seg_units;
    assign o_ledg  = ~w_alert & ~w_full;
    assign o_ledr  = w_full | w_alert;

endmodule

// File: tb/tb_passage_counter.sv
// Bench for passage_counter: per-cycle vector table on a CAPACITY=3 instance, scoreboard-checked,
// plus a hand-driven two-digit sequence on a CAPACITY=20 instance.
module tb_passage_counter;

    localparam int CAP_A = 3;
    localparam int CAP_B = 20;

    logic       clk;
    logic       a_rst_n, a_valid, a_dir;
    logic [6:0] a_count, a_hex1, a_hex0;
    logic       a_full, a_ledg, a_ledr;
    logic       b_rst_n, b_valid, b_dir;
    logic [6:0] b_count, b_hex1, b_hex0;
    logic       b_full, b_ledg, b_ledr;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        bit rst_n;
        bit ev_valid;
        bit ev_dir;
        int cnt;
        bit alert;
    } vec_t;

    typedef struct {
        logic [6:0] count;
        logic       full;
        logic [6:0] hex1;
        logic [6:0] hex0;
        logic       ledg;
        logic       ledr;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    passage_counter #(.CAPACITY(CAP_A), .ALERT_CYCLES(4)) u_dut_a (
        .i_clk(clk), .i_rst_n(a_rst_n), .i_ev_valid(a_valid), .i_ev_dir(a_dir),
        .o_count(a_count), .o_full(a_full), .o_hex1(a_hex1), .o_hex0(a_hex0),
        .o_ledg(a_ledg), .o_ledr(a_ledr)
    );

    passage_counter #(.CAPACITY(CAP_B), .ALERT_CYCLES(4)) u_dut_b (
        .i_clk(clk), .i_rst_n(b_rst_n), .i_ev_valid(b_valid), .i_ev_dir(b_dir),
        .o_count(b_count), .o_full(b_full), .o_hex1(b_hex1), .o_hex0(b_hex0),
        .o_ledg(b_ledg), .o_ledr(b_ledr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            9: return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic exp_t model(input int cnt, input bit alert, input int cap);
        exp_t e;
        e.count = 7'(cnt);
        e.full  = (cnt == cap);
        e.hex1  = alert ? 7'b0110000 : ((cnt / 10 == 0) ? 7'b1111111 : seg(cnt / 10));
        e.hex0  = alert ? 7'b1111110 : seg(cnt % 10);
        e.ledg  = !alert && !e.full;
        e.ledr  = e.full || alert;
        return e;
    endfunction

    function automatic void add(input bit r, input bit v, input bit d, input int cnt, input bit al);
        vec_t x;
        x.rst_n = r; x.ev_valid = v; x.ev_dir = d; x.cnt = cnt; x.alert = al;
        tbl.push_back(x);
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s (step %0d): got %b, expected %b", name, idx, act, exp);
    endtask

    task automatic pulse_b(input bit dir);
        @(negedge clk); b_valid = 1'b1; b_dir = dir;
        @(negedge clk); b_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        exp_t e;
        a_rst_n = 1'b0; a_valid = 1'b1; a_dir = 1'b0;
        b_rst_n = 1'b0; b_valid = 1'b0; b_dir = 1'b0;

        // reset with EV_VALID held high, then release: no count
        add(0,1,0,0,0); add(0,1,0,0,0); add(1,1,0,0,0); add(1,1,0,0,0); add(1,0,0,0,0);
        // three entry pulses to full
        add(1,1,1,1,0); add(1,0,1,1,0); add(1,0,1,1,0);
        add(1,1,1,2,0); add(1,0,1,2,0); add(1,0,1,2,0);
        add(1,1,1,3,0); add(1,0,1,3,0); add(1,0,1,3,0);
        // entry at full: 4-cycle alert, exit pulse inside it is dropped
        add(1,1,1,3,1); add(1,0,0,3,1); add(1,1,0,3,1); add(1,0,0,3,1);
        add(1,0,0,3,0); add(1,0,0,3,0);
        // exit held 10 cycles counts once
        for (int i = 0; i < 10; i++) add(1,1,0,2,0);
        add(1,0,0,2,0);
        add(1,1,0,1,0); add(1,0,0,1,0); add(1,1,0,0,0); add(1,0,0,0,0);
        // exit at empty: full 4-cycle alert dwell
        add(1,1,0,0,1); add(1,0,0,0,1); add(1,0,0,0,1); add(1,0,0,0,1); add(1,0,0,0,0);
        // exit at empty again, reset during 2nd alert cycle
        add(1,1,0,0,1); add(0,0,0,0,0); add(1,0,0,0,0);
        add(1,1,1,1,0); add(1,0,1,1,0);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            a_rst_n = tbl[i].rst_n;
            a_valid = tbl[i].ev_valid;
            a_dir   = tbl[i].ev_dir;
            sb.push_back(model(tbl[i].cnt, tbl[i].alert, CAP_A));
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check("count", i, 32'(a_count), 32'(e.count));
            check("full",  i, 32'(a_full),  32'(e.full));
            check("hex1",  i, 32'(a_hex1),  32'(e.hex1));
            check("hex0",  i, 32'(a_hex0),  32'(e.hex0));
            check("ledg",  i, 32'(a_ledg),  32'(e.ledg));
            check("ledr",  i, 32'(a_ledr),  32'(e.ledr));
        end

        // two-digit display on the larger instance
        @(negedge clk); b_rst_n = 1'b0;
        @(negedge clk); b_rst_n = 1'b1;
        for (int i = 0; i < 10; i++) pulse_b(1'b1);
        check("b_count_10", 10, 32'(b_count), 32'd10);
        check("b_hex1_10",  10, 32'(b_hex1),  32'(7'b1001111));
        check("b_hex0_10",  10, 32'(b_hex0),  32'(7'b0000001));
        check("b_full_10",  10, 32'(b_full),  32'd0);
        check("b_ledg_10",  10, 32'(b_ledg),  32'd1);
        pulse_b(1'b0);
        check("b_count_9", 9, 32'(b_count), 32'd9);
        check("b_hex1_9",  9, 32'(b_hex1),  32'(7'b1111111));
        check("b_hex0_9",  9, 32'(b_hex0),  32'(7'b0000100));
        check("b_ledr_9",  9, 32'(b_ledr),  32'd0);
        check("sb_empty",  0, 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
